// File: rtl/disp_pkg.sv
// Shared constants for the result display scanner.
// Digit count, active-low segment table and off codes.
package disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n is hex digit n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low 7-segment pattern (dp off).
// Ports: nib (4-bit digit in), seg (8-bit segments out).
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  assign seg = SEG_HEX[nib];

endmodule

// File: rtl/result_display_scan.sv
// Captures a 32-bit ALU result and scans it as 8 hex digits.
// Ports: clka/rsta, stba/dina/ofa/zfa capture, blka blanking,
//        ana digit enables, sega segments, leda flag LEDs.
module result_display_scan
  import disp_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        stba,
  input  logic [31:0] dina,
  input  logic        ofa,
  input  logic        zfa,
  input  logic        blka,
  output logic [7:0]  ana,
  output logic [7:0]  sega,
  output logic [1:0]  leda
);

  logic [31:0]           cap_q;
  logic                  of_q;
  logic                  zf_q;
  logic [DIV_W-1:0]      div_q;
  logic                  tick;
  logic [2:0]            idx_q;
  logic [2:0]            nidx;
  logic [7:0]            nseg;
  logic [7:0]            nan;
  logic [NUM_DIGITS-1:0] blank;

  assign tick = &div_q;
  assign nidx = idx_q + 3'd1;
  assign nan  = ~(8'd1 << nidx);

  hex_to_seg u_hex (
    .nib (cap_q[{nidx, 2'b00} +: 4]),
    .seg (nseg)
  );

  // Digit k is dark when it and every higher nibble
  // are zero; digit 0 always stays lit.
  always_comb begin
    blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      blank[k] = blka && ((cap_q >> (4 * k)) == 32'd0);
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      cap_q <= '0;
      of_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else if (stba) begin
      cap_q <= dina;
      of_q  <= ofa;
      zf_q  <= zfa;
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      idx_q <= 3'd7;
      ana   <= AN_OFF;
      sega  <= SEG_BLANK;
    end else if (tick) begin
      idx_q <= nidx;
      if (blank[nidx]) begin
        ana  <= AN_OFF;
        sega <= SEG_BLANK;
      end else begin
        ana  <= nan;
        sega <= nseg;
      end
    end
  end

  assign leda = {zf_q, of_q};

endmodule

// File: tb/tb_result_display_scan.sv
// Scoreboard bench for result_display_scan (DIV_W=2).
// Model pushes expected scan/LED values; monitor pops and checks.
module tb_result_display_scan;

  localparam int DIV_W = 2;
  localparam int PER   = 1 << DIV_W;

  logic        clka = 1'b0;
  logic        rsta = 1'b0;
  logic        stba = 1'b0;
  logic [31:0] dina = '0;
  logic        ofa  = 1'b0;
  logic        zfa  = 1'b0;
  logic        blka = 1'b0;
  logic [7:0]  ana;
  logic [7:0]  sega;
  logic [1:0]  leda;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  logic [1:0]  led_q [$];

  logic [31:0] mcap;
  logic        mof;
  logic        mzf;
  int          edges;

  logic [7:0] segtab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  result_display_scan #(.DIV_W(DIV_W)) dut (
    .clka (clka),
    .rsta (rsta),
    .stba (stba),
    .dina (dina),
    .ofa  (ofa),
    .zfa  (zfa),
    .blka (blka),
    .ana  (ana),
    .sega (sega),
    .leda (leda)
  );

  always #5 clka = ~clka;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] disp(input logic [31:0] cap,
                                       input logic blk,
                                       input int d);
    logic [31:0] hi;
    logic [3:0]  nib;
    logic [7:0]  an;
    hi  = cap >> (4 * d);
    nib = hi[3:0];
    if (blk && d != 0 && hi == 0) return 16'hFFFF;
    an = 8'hFF;
    an[d] = 1'b0;
    return {an, segtab[nib]};
  endfunction

  // Reference model: digit d is shown on every PER-th edge,
  // using the capture value held before that edge.
  always @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      mcap  = '0;
      mof   = 1'b0;
      mzf   = 1'b0;
      edges = 0;
      exp_q.delete();
      led_q.delete();
    end else begin
      edges++;
      if (edges % PER == 0)
        exp_q.push_back(disp(mcap, blka, (edges / PER - 1) % 8));
      if (stba) begin
        mcap = dina;
        mof  = ofa;
        mzf  = zfa;
      end
      led_q.push_back({mzf, mof});
    end
  end

  always @(negedge clka) begin
    if (rsta) begin
      while (led_q.size() > 0)
        chk("leda", {14'd0, leda}, {14'd0, led_q.pop_front()});
      if (exp_q.size() > 0)
        chk("scan", {ana, sega}, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clka);
      #1;
    end
  endtask

  task automatic strobe(input logic [31:0] d,
                        input logic o, input logic z);
    dina = d;
    ofa  = o;
    zfa  = z;
    stba = 1'b1;
    step(1);
    stba = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_out", {ana, sega}, 16'hFFFF);
    chk("rst_led", {14'd0, leda}, 16'd0);
    rsta = 1'b1;
    step(2);
    chk("pre_tick", {ana, sega}, 16'hFFFF);
    step(38);

    strobe(32'h1234ABCD, 1'b1, 1'b0);
    step(40);

    blka = 1'b1;
    strobe(32'h000000A0, 1'b0, 1'b0);
    step(40);
    strobe(32'h0, 1'b0, 1'b0);
    step(40);
    blka = 1'b0;

    for (int i = 0; i < PER && (edges % PER) != PER - 1; i++)
      step(1);
    strobe(32'hFFFFFFFF, 1'b0, 1'b0);
    step(40);

    step(6);
    #1;
    rsta = 1'b0;
    #1;
    chk("async_an_sg", {ana, sega}, 16'hFFFF);
    chk("async_led", {14'd0, leda}, 16'd0);
    step(2);
    rsta = 1'b1;
    step(40);

    strobe(32'h0, 1'b0, 1'b1);
    strobe(32'h7, 1'b0, 1'b0);
    step(40);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        strobe($urandom >> $urandom_range(0, 31),
               1'($urandom), 1'($urandom));
      else
        step(1);
      if ($urandom_range(0, 15) == 0) blka = ~blka;
    end
    step(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/result_display_scan.md
# result_display_scan

Downstream consumer of the single-cycle CPU's ALU result bus and overflow/zero flags. It captures a 32-bit result on a strobe and time-multiplexes it as eight hex digits onto a common-anode 7-segment display. The captured flags drive two LEDs. It sits between the CPU's `douta`/`ofa`/`zfa` outputs and the board pins, and runs on the same clock as the CPU's data side.

## Interface
- `DIV_W`, default 16: prescaler width. Digit period is 2^DIV_W clock cycles.
- `clka`  in  1  system clock; all state updates on the rising edge.
- `rsta`  in  1  reset, asynchronous, active-low.
- `stba`  in  1  capture strobe; when high at a rising edge, `dina`/`ofa`/`zfa` are captured.
- `dina`  in  32  ALU result to display.
- `ofa`  in  1  overflow flag, captured with `dina`.
- `zfa`  in  1  zero flag, captured with `dina`.
- `blka`  in  1  leading-zero blanking enable; level, sampled every tick.
- `ana`  out  8  digit enables, active-low; bit k selects digit k (k=0 is least significant nibble).
- `sega`  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- `leda`  out  2  {captured zf, captured of}, active-high.

## Operation
- Capture register (32+2 bits): loads on `stba`=1; otherwise holds. No other source modifies it.
- Prescaler: DIV_W-bit up-counter, free-running, wraps to 0. A tick is asserted in the cycle when the counter equals all-ones.
- Digit index `idx` (3 bits): advances idx+1 mod 8 on tick (7 wraps to 0).
- On tick, `ana`/`sega` are registered for the new index, using the capture register value present before that edge.
  - `ana` = all ones except bit new_idx = 0, unless that digit is blanked.
  - A blanked digit drives `ana`=8'hFF and `sega`=8'hFF.
- Blanking: digit k (k≥1) is blanked iff `blka`=1 and nibbles k..7 of the capture register are all zero. Digit 0 is never blanked, so the value 0 shows a single "0".
- Hex decode for `sega` (dp always 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- `leda` is driven directly from the captured flags and updates the cycle after capture.

## Timing
- Reset (async, immediate): capture=0, flags=0, prescaler=0, idx=7, `ana`=8'hFF, `sega`=8'hFF, `leda`=2'b00.
- First tick occurs 2^DIV_W−1 cycles after the first post-reset edge. `ana`=8'hFE with digit 0 appears after that edge. Subsequent digits follow every 2^DIV_W cycles.
- Capture latency:
  - Register updates at the strobe edge.
  - `leda` is visible after the same edge.
  - A digit shows the new value at the first tick edge strictly after the strobe edge that selects that digit.
- Strobe and tick on the same edge: the display registers use the old captured value; the new value shows from the next tick.
- Back-to-back strobes: the last one wins. No queueing.
- `rsta` asserted mid-scan: all outputs go to reset values asynchronously. The scan restarts from idx=7 on deassert.
- Outputs are registered, so there are no combinational paths from inputs to pins.

## Structure
- Shared package `disp_pkg`:
  - `NUM_DIGITS`=8.
  - The 16-entry active-low segment constants above.
  - `SEG_BLANK`=8'hFF and `AN_OFF`=8'hFF.
- Sub-module `hex_to_seg`: combinational, 4-bit nibble in, 8-bit active-low segment out, table from `disp_pkg`. Instantiated once; its input is the nibble of the capture register at the next index.
- The top contains the capture register, prescaler, index counter, blank-detect logic (7 OR-reductions), and the output registers.

## Test plan
Run with `DIV_W`=2 (tick every 4 cycles).
- Reset, no strobe, 40 cycles, `blka`=0 -> `ana` cycles FE,FD,FB,...,7F with `sega`=C0 each. First FE appears 4 edges after release. `leda`=00.
- Strobe `dina`=32'h1234ABCD, `ofa`=1, `zfa`=0, `blka`=0 -> `leda`=01 next cycle. One full scan gives digits 0..7 `sega`= A1,C6,83,88,99,B0,A4,F9.
- `dina`=32'h000000A0, `blka`=1 -> digits 0,1 show C0,88. Digits 2..7 give `ana`=FF, `sega`=FF. `dina`=0 with `blka`=1 -> only digit 0 lit, showing C0.
- Strobe asserted on the same edge as a tick (old value 0, new value FFFFFFFF) -> that tick's digit still shows C0. The following ticks show 8E.
- Assert `rsta` low mid-scan, between edges -> `ana`/`sega`=FF and `leda`=00 immediately, without waiting for a clock. After release, digit 0 appears after 4 edges and shows C0.
- Strobe with `zfa`=1 for `dina`=0 -> `leda`=10. A second strobe one cycle later with 32'h7 -> `leda`=00, and digit 0 then shows F8.
